// File: rtl/alu_issue_unit_if.sv
// Request/response handshake bundle between the core control FSM and the ALU issue unit.
// master = requester side (control FSM), slave = issue unit side.
// Both channels are valid/ready; the data fields are qualified by their valid.
interface alu_issue_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_alu_op;
    logic [2:0]       req_funct3;
    logic             req_funct7_5;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;

    modport master (
        output req_valid, req_alu_op, req_funct3, req_funct7_5, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
    );

    modport slave (
        input  req_valid, req_alu_op, req_funct3, req_funct7_5, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Decodes an ALU request, drives the combinational ALU, captures out/zero and returns them.
// Latency: SETTLE_CYCLES edges from accept to rsp_valid (legal), rsp_valid at the accept edge (illegal).
// Backpressure: one op in flight; req_ready only in IDLE, response held until rsp_ready.
module alu_issue_unit #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_unit_if.slave      bus,
    output logic [3:0]           alu_ctrl,
    output logic [WIDTH-1:0]     alu_ina,
    output logic [WIDTH-1:0]     alu_inb,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_zero,
    output logic [CNT_WIDTH-1:0] op_count
);
    // Settle counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    settle;
    logic [3:0]       dec_ctrl;
    logic             dec_legal;
    logic [WIDTH-1:0] res_hold;
    logic             zero_hold;
    logic             illegal_hold;
    logic             accept;
    logic             rsp_done;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign rsp_done = (state == RESP) && bus.rsp_ready;

    assign bus.req_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_result  = res_hold;
    assign bus.rsp_zero    = zero_hold;
    assign bus.rsp_illegal = illegal_hold;

    // Map ALUOp class plus funct fields onto the ALU control code; anything unlisted is illegal.
    always_comb begin
        dec_ctrl  = CTRL_ADD;
        dec_legal = 1'b0;
        unique case (bus.req_alu_op)
            2'b00: begin
                dec_ctrl  = CTRL_ADD;
                dec_legal = 1'b1;
            end
            2'b01: begin
                dec_ctrl  = CTRL_SUB;
                dec_legal = 1'b1;
            end
            2'b10: begin
                unique case (bus.req_funct3)
                    3'b000: begin
                        dec_ctrl  = bus.req_funct7_5 ? CTRL_SUB : CTRL_ADD;
                        dec_legal = 1'b1;
                    end
                    3'b111: begin
                        dec_ctrl  = CTRL_AND;
                        dec_legal = 1'b1;
                    end
                    3'b110: begin
                        dec_ctrl  = CTRL_OR;
                        dec_legal = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            2'b11: begin
                // Immediates have no subtract form, so bit 30 is part of the immediate here.
                unique case (bus.req_funct3)
                    3'b000: begin
                        dec_ctrl  = CTRL_ADD;
                        dec_legal = 1'b1;
                    end
                    3'b111: begin
                        dec_ctrl  = CTRL_AND;
                        dec_legal = 1'b1;
                    end
                    3'b110: begin
                        dec_ctrl  = CTRL_OR;
                        dec_legal = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: illegal requests skip the ALU entirely and answer straight away.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dec_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (settle == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive lines: loaded only on a legal accept, otherwise held so the ALU sees no glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl <= '0;
            alu_ina  <= '0;
            alu_inb  <= '0;
        end else if (accept && dec_legal) begin
            alu_ctrl <= dec_ctrl;
            alu_ina  <= bus.req_a;
            alu_inb  <= bus.req_b;
        end
    end

    // Settle countdown: loaded on accept, counts down while the ALU output propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= '0;
        end else if (accept && dec_legal) begin
            settle <= SETTLE_LOAD;
        end else if ((state == EXEC) && (settle != '0)) begin
            settle <= settle - 1'b1;
        end
    end

    // Response payload: ALU sample at end of settle, or the fixed illegal pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_hold     <= '0;
            zero_hold    <= 1'b0;
            illegal_hold <= 1'b0;
        end else if (accept && !dec_legal) begin
            res_hold     <= '1;
            zero_hold    <= 1'b0;
            illegal_hold <= 1'b1;
        end else if ((state == EXEC) && (settle == '0)) begin
            res_hold     <= alu_out;
            zero_hold    <= alu_zero;
            illegal_hold <= 1'b0;
        end
    end

    // Completed-operation counter, bumped on each response handshake; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_done) begin
            op_count <= op_count + 1'b1;
        end
    end
endmodule
